// File: rtl/zx_video_pkg.sv
// rtl/zx_video_pkg.sv - shared types and constants for the screen-memory shadow
// Purpose: RAM geometry, screen bank numbers, the queued-write word, the
//          shadow state encoding and the CPU address bank decoder.
// Ports:   none (package).
package zx_video_pkg;

  localparam int VRAM_AW = 15;
  localparam logic [2:0] BANK5 = 3'd5;
  localparam logic [2:0] BANK7 = 3'd7;

  typedef struct packed {
    logic [14:0] a;
    logic [7:0]  d;
  } vram_wr_t;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } vs_state_e;

  // Returns {hit, bank7}. 4000h-7FFFh is always bank 5; C000h-FFFFh is a
  // screen bank only when 128K paging maps bank 5 or 7 there.
  function automatic logic [1:0] bank_decode(input logic [1:0] seg,
                                             input logic       paging,
                                             input logic [2:0] page);
    logic [1:0] r;
    r = 2'b00;
    if (seg == 2'b01) begin
      r = 2'b10;
    end else if (seg == 2'b11 && paging && page == BANK5) begin
      r = 2'b10;
    end else if (seg == 2'b11 && paging && page == BANK7) begin
      r = 2'b11;
    end
    return r;
  endfunction

endpackage

// File: rtl/vram_shadow_if.sv
// rtl/vram_shadow_if.sv - CPU snoop bus and video fetch port bundle
// Purpose: groups the Z80 bus signals seen by the shadow and the video
//          controller's fetch address / data pair.
// Ports:   master drives the CPU bus and vram_addr, receives vram_dout;
//          slave (the shadow) observes the bus and drives vram_dout.
interface vram_shadow_if;
  logic [15:0] addr;
  logic [7:0]  din;
  logic        nMREQ;
  logic        nWR;
  logic        nRFSH;
  logic        m128;
  logic [2:0]  page_ram;
  logic [14:0] vram_addr;
  logic [7:0]  vram_dout;

  modport master (
    output addr, din, nMREQ, nWR, nRFSH, m128, page_ram, vram_addr,
    input  vram_dout
  );

  modport slave (
    input  addr, din, nMREQ, nWR, nRFSH, m128, page_ram, vram_addr,
    output vram_dout
  );
endinterface

// File: rtl/vram_wq.sv
// rtl/vram_wq.sv - synchronous write queue for snooped screen writes
// Purpose: DEPTH-entry FIFO (DEPTH a power of two, >= 2) of vram_wr_t.
// Ports:   clk_sys/reset; push + push_data in; pop in, pop_data out (head);
//          full/empty status; drop pulses when a push is lost.
module vram_wq
  import zx_video_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk_sys,
  input  logic     reset,
  input  logic     push,
  input  vram_wr_t push_data,
  input  logic     pop,
  output vram_wr_t pop_data,
  output logic     full,
  output logic     empty,
  output logic     drop
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  vram_wr_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q;
  logic [PW-1:0]   rd_ptr_q;
  logic [PW:0]     count_q;
  logic            do_push;
  logic            do_pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign do_pop   = pop & ~empty;
  // A pop in the same cycle frees the slot the push lands in.
  assign do_push  = push & (~full | do_pop);
  assign drop     = push & full & ~do_pop;
  assign pop_data = mem_q[rd_ptr_q];

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + (PW + 1)'(do_push) - (PW + 1)'(do_pop);
    end
  end

endmodule

// File: rtl/vram_shadow.sv
// rtl/vram_shadow.sv - snooping screen-memory shadow feeding the video controller
// Purpose: captures CPU writes to RAM banks 5/7, queues them, commits them to
//          a 32 KB single-port RAM in slots the video fetch cannot observe,
//          and serves video fetches with one-cycle latency.
// Ports:   clk_sys, reset (sync, active-high); ce_28m/ce_7mp/ce_7mn timing
//          enables; bus (slave modport: CPU bus in, vram_addr in, vram_dout
//          out); ready (cleared and snooping); overflow (sticky lost write).
module vram_shadow
  import zx_video_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic         clk_sys,
  input  logic         reset,
  input  logic         ce_28m,
  input  logic         ce_7mp,
  input  logic         ce_7mn,
  vram_shadow_if.slave bus,
  output logic         ready,
  output logic         overflow
);

  vs_state_e          state_q, state_d;
  logic [VRAM_AW-1:0] clr_cnt_q, clr_cnt_d;

  logic               wr_act;
  logic               wr_act_q;
  logic               wr_prev_q;
  logic               snoop_edge;
  logic [1:0]         dec;
  logic               wq_push;
  vram_wr_t           wq_push_data;
  vram_wr_t           wq_head;
  logic               wq_pop;
  logic               wq_full;
  logic               wq_empty;
  logic               wq_drop;
  logic               overflow_q;

  logic               ram_we;
  logic               ram_re;
  logic [VRAM_AW-1:0] ram_wa;
  logic [7:0]         ram_wd;
  logic               snoop_en;
  logic               ready_c;
  logic               slot;

  logic [7:0]         ram_q [2**VRAM_AW];
  logic [7:0]         rd_q;

  // Snoop front end: one register stage on the write strobe, then edge detect.
  assign wr_act = ~bus.nMREQ & ~bus.nWR & bus.nRFSH;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      wr_act_q  <= 1'b0;
      wr_prev_q <= 1'b0;
    end else begin
      wr_act_q  <= wr_act;
      wr_prev_q <= wr_act_q;
    end
  end

  assign snoop_edge   = wr_act_q & ~wr_prev_q;
  assign dec          = bank_decode(bus.addr[15:14], bus.m128, bus.page_ram);
  assign wq_push      = snoop_edge & dec[1] & snoop_en;
  assign wq_push_data = '{a: {dec[0], bus.addr[13:0]}, d: bus.din};

  vram_wq #(.DEPTH(FIFO_DEPTH)) u_wq (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .push      (wq_push),
    .push_data (wq_push_data),
    .pop       (wq_pop),
    .pop_data  (wq_head),
    .full      (wq_full),
    .empty     (wq_empty),
    .drop      (wq_drop)
  );

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      overflow_q <= 1'b0;
    end else if (wq_drop & wq_full) begin
      overflow_q <= 1'b1;
    end
  end

  // A 28 MHz tick away from both 7 MHz phases is never sampled by video.
  assign slot = ce_28m & ~ce_7mp & ~ce_7mn & ~wq_empty;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q   <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == ST_CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (clr_cnt_q == '1) state_d = ST_RUN;
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_wa   = clr_cnt_q;
    ram_wd   = 8'h00;
    wq_pop   = 1'b0;
    snoop_en = 1'b0;
    ready_c  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        ram_we = 1'b1;
      end
      ST_RUN: begin
        ready_c  = 1'b1;
        snoop_en = 1'b1;
        if (slot) begin
          ram_we = 1'b1;
          ram_wa = wq_head.a;
          ram_wd = wq_head.d;
          wq_pop = 1'b1;
        end else begin
          ram_re = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (ram_we) ram_q[ram_wa] <= ram_wd;
  end

  // Read register holds across write slots so video always sees the last fetch.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      rd_q <= 8'h00;
    end else if (ram_re) begin
      rd_q <= ram_q[bus.vram_addr];
    end
  end

  assign bus.vram_dout = rd_q;
  assign ready         = ready_c;
  assign overflow      = overflow_q;

endmodule
